vending_machine_param: RTL and testbench
========================================

# vending_machine_param

Parametrised vending-machine controller: N selectable items with per-item price and stock counters, four coin denominations (10/5/2/1), bounded credit with coin rejection, cancel/refund, and greedy change paid out serially, one coin pulse per clock. It is the next-generation replacement for the fixed three-item machine and sits between the coin/selection front panel and the item and coin-hopper actuators.

## Interface
- N_ITEMS, 3: number of items.
- PRICE_W, 6: width of one price field.
- PRICES, {6'd25,6'd20,6'd15}: packed prices; item i = PRICES[i*PRICE_W +: PRICE_W], each ≥1 and ≤ CREDIT_MAX.
- CREDIT_MAX, 40: credit ceiling; CREDIT_W = $clog2(CREDIT_MAX+1) (localparam).
- STOCK_W, 4: stock counter width.
- INIT_STOCK, 5: stock loaded by reset and restock, < 2^STOCK_W.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- b10, b5, b2, b1  in  1 each  coin-present levels.
- sel  in  N_ITEMS  item request levels.
- cancel  in  1  refund request level.
- restock  in  1  reload all stock to INIT_STOCK.
- item_out  out  N_ITEMS  one-cycle dispense pulse.
- c10, c5, c2, c1  out  1 each  one-cycle change-coin pulse.
- coin_reject  out  1  one-cycle pulse, coins returned unaccepted.
- credit  out  CREDIT_W  current credit.
- sold_out  out  N_ITEMS  bit i = stock[i]==0.
- busy  out  1  high when state != IDLE.

## Operation
- All inputs go through a registered edge detector (prev regs reset to 0); an event = input high now, low in prev register. Held levels count once; input high at reset release counts as one event.
- States: IDLE, CHANGE.
- IDLE priority per cycle:
  1. cancel event: credit>0 → CHANGE; credit==0 → no action. Coin/sel events same cycle are rejected (coin_reject if any coin event).
  2. sel event: lowest set index i with stock[i]>0 and credit ≥ price[i] is accepted: item_out[i]<=1, stock[i]--, credit<=credit-price[i]; remainder>0 → CHANGE else stay IDLE. Coin events same cycle → coin_reject. Sel with insufficient credit or sold-out: ignored, no pulse.
  3. coin events: sum = 10·b10+5·b5+2·b2+1·b1 events; credit+sum ≤ CREDIT_MAX → credit += sum; otherwise all coins that cycle rejected (coin_reject), credit unchanged.
  4. restock event (IDLE only, any same-cycle action still applied): all stock <= INIT_STOCK. Ignored in CHANGE.
- CHANGE: each edge emits exactly one coin, greedy: credit ≥10 → c10, ≥5 → c5, ≥2 → c2, else c1; credit decremented by that value. When new credit is 0 → IDLE. All coin events in CHANGE → coin_reject; sel/cancel ignored.
- Refund after vend is automatic (no credit carried over).
- Arithmetic: sum computed at CREDIT_W+1 bits; comparisons unsigned; credit never exceeds CREDIT_MAX nor underflows.

## Timing
- Reset (async, any time incl. mid-CHANGE): state IDLE, credit 0, stock all INIT_STOCK, item_out/c*/coin_reject 0, sold_out 0, busy 0, edge regs 0. Partial change in progress is lost.
- All outputs registered. Input event at edge k → credit/item_out/coin_reject visible after edge k.
- Vend with change: item_out at cycle after edge k; first change coin after edge k+1; change of value v takes greedy-coin-count cycles, busy high from after edge k until the last coin cycle ends.
- Cancel: first coin after edge k+1? No—cancel transitions at edge k, first coin after edge k+1.
- Pulses last exactly one cycle; consecutive coin pulses may be same denomination on back-to-back cycles.

## Test plan
- Reset: hold reset=0, drive all inputs high → all outputs 0, credit 0, sold_out 0; release with b10 high → credit 10 one cycle later, once.
- Vend+change: insert 10,10,10,2,1 (separate events) → credit 33; sel[0] → item_out[0] one cycle, credit 18, then c10,c5,c2,c1 on four consecutive cycles, credit 0, busy low.
- Cancel: credit 30, cancel → c10 three consecutive cycles, no item_out; cancel with credit 0 → no activity.
- Overflow/busy: credit 40, b1 → coin_reject, credit 40; coin during CHANGE → coin_reject, change sequence unaffected.
- Stock: INIT_STOCK=1, credit 20, sel[1] → item_out[1], sold_out[1]=1; credit 20, sel[1] → ignored, credit 20; restock → sold_out 0.
- Priority: credit 10, sel[0] → ignored; credit 25, sel=3'b011 → item_out[0], change 10; sel+cancel same cycle → refund only.

Source files
------------

// File: rtl/vending_machine_param.sv
// Parametrised vending-machine controller: N items with price/stock, four coin
// denominations, bounded credit, cancel/refund and serial greedy change.
module vending_machine_param #(
    parameter int unsigned N_ITEMS = 3,
    parameter int unsigned PRICE_W = 6,
    parameter logic [N_ITEMS*PRICE_W-1:0] PRICES = {6'd25, 6'd20, 6'd15},
    parameter int unsigned CREDIT_MAX = 40,
    parameter int unsigned STOCK_W = 4,
    parameter int unsigned INIT_STOCK = 5,
    localparam int unsigned CREDIT_W = $clog2(CREDIT_MAX + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                b10,
    input  logic                b5,
    input  logic                b2,
    input  logic                b1,
    input  logic [N_ITEMS-1:0]  sel,
    input  logic                cancel,
    input  logic                restock,
    output logic [N_ITEMS-1:0]  item_out,
    output logic                c10,
    output logic                c5,
    output logic                c2,
    output logic                c1,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic [N_ITEMS-1:0]  sold_out,
    output logic                busy
);

    localparam int unsigned CW1 = CREDIT_W + 1;
    localparam int unsigned AW  = ((CREDIT_W > PRICE_W) ? CREDIT_W : PRICE_W) + 1;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_CHANGE = 1'b1;

    logic [0:0]                      state, state_n;
    logic [CREDIT_W-1:0]             credit_n;
    logic [N_ITEMS-1:0][STOCK_W-1:0] stock, stock_n;
    logic [N_ITEMS-1:0]              item_n, sold_out_n;
    logic [3:0]                      chg_n;
    logic                            reject_n;

    logic [3:0]         prev_coin;
    logic [N_ITEMS-1:0] prev_sel;
    logic               prev_cancel, prev_restock;

    logic [3:0]         coin_ev;
    logic [N_ITEMS-1:0] sel_ev;
    logic               cancel_ev, restock_ev;

    logic               vend_hit;
    logic [N_ITEMS-1:0] vend_vec;
    logic [PRICE_W-1:0] vend_price;
    logic [CW1-1:0]     coin_sum;
    logic [3:0]         greedy_vec;
    logic [CREDIT_W-1:0] greedy_amt;

    // Rising-edge events: held levels count once.
    assign coin_ev    = {b10, b5, b2, b1} & ~prev_coin;
    assign sel_ev     = sel & ~prev_sel;
    assign cancel_ev  = cancel & ~prev_cancel;
    assign restock_ev = restock & ~prev_restock;

    assign coin_sum = CW1'(coin_ev[3] ? 10 : 0) + CW1'(coin_ev[2] ? 5 : 0)
                    + CW1'(coin_ev[1] ? 2 : 0) + CW1'(coin_ev[0] ? 1 : 0);

    // Lowest requested item that is in stock and affordable.
    always_comb begin
        vend_hit   = 1'b0;
        vend_vec   = '0;
        vend_price = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (!vend_hit && sel_ev[i] && (stock[i] != '0) &&
                (AW'(credit) >= AW'(PRICES[i*PRICE_W +: PRICE_W]))) begin
                vend_hit    = 1'b1;
                vend_vec[i] = 1'b1;
                vend_price  = PRICES[i*PRICE_W +: PRICE_W];
            end
        end
    end

    // Largest coin not exceeding the remaining credit.
    always_comb begin
        greedy_vec = 4'b0001;
        greedy_amt = CREDIT_W'(1);
        if (32'(credit) >= 32'd10) begin
            greedy_vec = 4'b1000;
            greedy_amt = CREDIT_W'(10);
        end else if (32'(credit) >= 32'd5) begin
            greedy_vec = 4'b0100;
            greedy_amt = CREDIT_W'(5);
        end else if (32'(credit) >= 32'd2) begin
            greedy_vec = 4'b0010;
            greedy_amt = CREDIT_W'(2);
        end
    end

    always_comb begin
        state_n  = state;
        credit_n = credit;
        stock_n  = stock;
        item_n   = '0;
        chg_n    = '0;
        reject_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (cancel_ev) begin
                    reject_n = |coin_ev;
                    if (credit != '0) state_n = S_CHANGE;
                end else if (vend_hit) begin
                    reject_n = |coin_ev;
                    item_n   = vend_vec;
                    credit_n = CREDIT_W'(AW'(credit) - AW'(vend_price));
                    for (int i = 0; i < N_ITEMS; i++) begin
                        if (vend_vec[i]) stock_n[i] = stock[i] - STOCK_W'(1);
                    end
                    if (credit_n != '0) state_n = S_CHANGE;
                end else if (|coin_ev) begin
                    if ((CW1'(credit) + coin_sum) <= CW1'(CREDIT_MAX))
                        credit_n = CREDIT_W'(CW1'(credit) + coin_sum);
                    else
                        reject_n = 1'b1;
                end
                if (restock_ev) begin
                    for (int i = 0; i < N_ITEMS; i++) stock_n[i] = STOCK_W'(INIT_STOCK);
                end
            end
            default: begin
                reject_n = |coin_ev;
                chg_n    = greedy_vec;
                credit_n = credit - greedy_amt;
                if (credit_n == '0) state_n = S_IDLE;
            end
        endcase
        for (int i = 0; i < N_ITEMS; i++) sold_out_n[i] = (stock_n[i] == '0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            credit       <= '0;
            for (int i = 0; i < N_ITEMS; i++) stock[i] <= STOCK_W'(INIT_STOCK);
            prev_coin    <= '0;
            prev_sel     <= '0;
            prev_cancel  <= 1'b0;
            prev_restock <= 1'b0;
            item_out     <= '0;
            {c10, c5, c2, c1} <= 4'b0000;
            coin_reject  <= 1'b0;
            sold_out     <= '0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            credit       <= credit_n;
            stock        <= stock_n;
            prev_coin    <= {b10, b5, b2, b1};
            prev_sel     <= sel;
            prev_cancel  <= cancel;
            prev_restock <= restock;
            item_out     <= item_n;
            {c10, c5, c2, c1} <= chg_n;
            coin_reject  <= reject_n;
            sold_out     <= sold_out_n;
            busy         <= (state_n != S_IDLE);
        end
    end

endmodule

// File: tb/tb_vending_machine_param.sv
// Self-checking bench for vending_machine_param: directed scenarios plus random
// stimulus compared against a queue-based behavioural model.
module tb_vending_machine_param;

    logic       clock = 1'b0;
    logic       reset;
    logic       b10, b5, b2, b1, cancel, restock;
    logic [2:0] sel;
    logic [2:0] item_out, sold_out;
    logic       c10, c5, c2, c1, coin_reject, busy;
    logic [5:0] credit;

    int errors = 0;
    int checks = 0;

    vending_machine_param dut (
        .clock(clock), .reset(reset),
        .b10(b10), .b5(b5), .b2(b2), .b1(b1),
        .sel(sel), .cancel(cancel), .restock(restock),
        .item_out(item_out), .c10(c10), .c5(c5), .c2(c2), .c1(c1),
        .coin_reject(coin_reject), .credit(credit),
        .sold_out(sold_out), .busy(busy)
    );

    always #5 clock = ~clock;

    // Behavioural model: credit as an integer, pending change as a coin queue.
    int         price [3] = '{15, 20, 25};
    int         m_credit;
    int         m_stock [3];
    int         m_q [$];
    int         m_item, m_coin;
    bit         m_rej;
    logic [3:0] m_prev_coin;
    logic [2:0] m_prev_sel;
    logic       m_prev_cancel, m_prev_restock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_credit = 0;
        foreach (m_stock[i]) m_stock[i] = 5;
        m_q.delete();
        m_item = 0; m_coin = 0; m_rej = 0;
        m_prev_coin = '0; m_prev_sel = '0; m_prev_cancel = 0; m_prev_restock = 0;
    endtask

    task automatic build_change(input int v);
        int c;
        while (v > 0) begin
            c = (v >= 10) ? 10 : (v >= 5) ? 5 : (v >= 2) ? 2 : 1;
            m_q.push_back(c);
            v -= c;
        end
    endtask

    task automatic model_step();
        logic [3:0] cev;
        logic [2:0] sev;
        bit cnl, rst, hit;
        int sum;
        cev = {b10, b5, b2, b1} & ~m_prev_coin;
        sev = sel & ~m_prev_sel;
        cnl = cancel & !m_prev_cancel;
        rst = restock & !m_prev_restock;
        m_prev_coin = {b10, b5, b2, b1};
        m_prev_sel = sel; m_prev_cancel = cancel; m_prev_restock = restock;
        m_item = 0; m_coin = 0; m_rej = 0;
        if (m_q.size() > 0) begin
            m_coin = m_q.pop_front();
            m_credit -= m_coin;
            m_rej = (cev != 0);
        end else begin
            if (cnl) begin
                if (m_credit > 0) build_change(m_credit);
                m_rej = (cev != 0);
            end else begin
                hit = 0;
                for (int i = 0; i < 3; i++) begin
                    if (!hit && sev[i] && m_stock[i] > 0 && m_credit >= price[i]) begin
                        hit = 1;
                        m_item = 1 << i;
                        m_stock[i]--;
                        m_credit -= price[i];
                        build_change(m_credit);
                        m_rej = (cev != 0);
                    end
                end
                if (!hit && cev != 0) begin
                    sum = 10*int'(cev[3]) + 5*int'(cev[2]) + 2*int'(cev[1]) + int'(cev[0]);
                    if (m_credit + sum <= 40) m_credit += sum;
                    else m_rej = 1;
                end
            end
            if (rst) foreach (m_stock[i]) m_stock[i] = 5;
        end
    endtask

    function automatic logic [3:0] coin_enc(input int v);
        return (v == 10) ? 4'b1000 : (v == 5) ? 4'b0100 : (v == 2) ? 4'b0010 :
               (v == 1) ? 4'b0001 : 4'b0000;
    endfunction

    task automatic tick();
        logic [2:0] so;
        @(posedge clock);
        model_step();
        #1;
        for (int i = 0; i < 3; i++) so[i] = (m_stock[i] == 0);
        chk("item_out", 32'(item_out), 32'(m_item));
        chk("change", 32'({c10, c5, c2, c1}), 32'(coin_enc(m_coin)));
        chk("coin_reject", 32'(coin_reject), 32'(m_rej));
        chk("credit", 32'(credit), 32'(m_credit));
        chk("sold_out", 32'(sold_out), 32'(so));
        chk("busy", 32'(busy), 32'(m_q.size() > 0));
    endtask

    task automatic clear_inputs();
        {b10, b5, b2, b1, cancel, restock} = '0;
        sel = '0;
    endtask

    task automatic pulse_coin(input int v);
        case (v)
            10: b10 = 1;
            5:  b5  = 1;
            2:  b2  = 1;
            default: b1 = 1;
        endcase
        tick();
        {b10, b5, b2, b1} = '0;
        tick();
    endtask

    task automatic pulse_sel(input logic [2:0] s);
        sel = s; tick();
        sel = '0; tick();
    endtask

    task automatic pulse_cancel();
        cancel = 1; tick();
        cancel = 0; tick();
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && m_q.size() > 0; k++) tick();
    endtask

    initial begin
        logic [3:0] seq [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

        // Reset held with every input high: outputs stay cleared.
        reset = 0;
        {b10, b5, b2, b1, cancel, restock} = '1;
        sel = '1;
        m_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_item", 32'(item_out), 0);
        chk("rst_coins", 32'({c10, c5, c2, c1, coin_reject}), 0);
        chk("rst_credit", 32'(credit), 0);
        chk("rst_sold_out", 32'(sold_out), 0);
        chk("rst_busy", 32'(busy), 0);
        clear_inputs();
        b10 = 1;
        @(negedge clock);
        reset = 1;
        tick();
        chk("release_credit", 32'(credit), 10);
        tick();
        chk("release_once", 32'(credit), 10);
        b10 = 0;
        tick();
        pulse_cancel();
        drain();

        // Vend with change 18 -> 10,5,2,1.
        pulse_coin(10); pulse_coin(10); pulse_coin(10); pulse_coin(2); pulse_coin(1);
        chk("credit33", 32'(credit), 33);
        sel = 3'b001;
        tick();
        chk("vend_item", 32'(item_out), 1);
        chk("vend_credit", 32'(credit), 18);
        sel = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("chg_seq", 32'({c10, c5, c2, c1}), 32'(seq[k]));
        end
        chk("chg_credit", 32'(credit), 0);
        chk("chg_busy", 32'(busy), 0);

        // Cancel with 30, then cancel with nothing.
        pulse_coin(10); pulse_coin(10); pulse_coin(10);
        cancel = 1;
        tick();
        chk("cancel_busy", 32'(busy), 1);
        cancel = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("refund_c10", 32'({c10, c5, c2, c1, item_out}), 32'(7'b1000_000));
        end
        chk("refund_done", 32'(busy), 0);
        pulse_cancel();
        chk("cancel_empty", 32'(busy), 0);

        // Ceiling overflow, then coin arriving during change.
        pulse_coin(10); pulse_coin(10); pulse_coin(10); pulse_coin(10);
        b1 = 1;
        tick();
        chk("ovf_reject", 32'(coin_reject), 1);
        chk("ovf_credit", 32'(credit), 40);
        b1 = 0;
        tick();
        cancel = 1; tick(); cancel = 0;
        b5 = 1;
        tick();
        chk("chg_reject", 32'(coin_reject), 1);
        chk("chg_coin", 32'({c10, c5, c2, c1}), 32'(4'b1000));
        b5 = 0;
        drain();

        // Exhaust item 1, refused sale, restock.
        for (int n = 0; n < 5; n++) begin
            pulse_coin(10); pulse_coin(10);
            pulse_sel(3'b010);
        end
        chk("sold_out1", 32'(sold_out), 32'(3'b010));
        pulse_coin(10); pulse_coin(10);
        pulse_sel(3'b010);
        chk("soldout_credit", 32'(credit), 20);
        restock = 1; tick(); restock = 0; tick();
        chk("restocked", 32'(sold_out), 0);
        pulse_cancel();
        drain();

        // Priority: insufficient credit, lowest index wins, cancel beats sel.
        pulse_coin(10);
        pulse_sel(3'b001);
        chk("short_credit", 32'(credit), 10);
        pulse_coin(10); pulse_coin(5);
        sel = 3'b011;
        tick();
        chk("low_index", 32'(item_out), 1);
        chk("low_index_chg", 32'(credit), 10);
        sel = '0;
        drain();
        pulse_coin(10); pulse_coin(10);
        sel = 3'b001; cancel = 1;
        tick();
        chk("cancel_wins", 32'(item_out), 0);
        sel = '0; cancel = 0;
        drain();

        // Asynchronous reset in the middle of a refund.
        pulse_coin(10); pulse_coin(10); pulse_coin(10);
        cancel = 1; tick(); cancel = 0;
        tick();
        reset = 0;
        #1;
        chk("midchg_credit", 32'(credit), 0);
        chk("midchg_busy", 32'(busy), 0);
        chk("midchg_coins", 32'({c10, c5, c2, c1}), 0);
        m_reset();
        @(negedge clock);
        reset = 1;
        tick();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            b10 = ($urandom_range(0, 5) == 0);
            b5  = ($urandom_range(0, 5) == 0);
            b2  = ($urandom_range(0, 5) == 0);
            b1  = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < 3; i++) sel[i] = ($urandom_range(0, 3) == 0);
            cancel  = ($urandom_range(0, 11) == 0);
            restock = ($urandom_range(0, 40) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
